// File: rtl/fade_frame_source.sv
// fade_frame_source
// AXI-Stream frame transmitter that sits in front of the fade IFFT core.
// A frame of N complex bins is held in an internal RAM that is loaded
// through a simple write port while the block is idle. A start pulse
// latches a transform-config word and sends it once on the config
// channel. The frame is then streamed on the data channel, with tlast on
// bin N-1. In continuous mode frames repeat with a single idle cycle
// between them.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start, continuous       run control (continuous sampled at frame end)
//   cfg_word                config word latched on an accepted start
//   wr_en/wr_addr/wr_data   bin RAM write port ({imag, real})
//   wr_err                  pulse: a write was dropped because busy
//   m_axis_config_*         config channel (single beat per run)
//   m_axis_data_*           data channel, tlast on bin N-1
//   busy                    high in any state except IDLE
//   frame_done              pulse on the cycle after the tlast beat
//   frame_count             frames completed since reset (wraps)
module fade_frame_source #(
    parameter int N_LOG2 = 5,
    parameter int DATA_W = 16,
    parameter int CFG_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic [CFG_W-1:0]    cfg_word,
    input  logic                wr_en,
    input  logic [N_LOG2-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic                wr_err,
    output logic [CFG_W-1:0]    m_axis_config_tdata,
    output logic                m_axis_config_tvalid,
    input  logic                m_axis_config_tready,
    output logic [2*DATA_W-1:0] m_axis_data_tdata,
    output logic                m_axis_data_tvalid,
    input  logic                m_axis_data_tready,
    output logic                m_axis_data_tlast,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_count
);

    localparam int N  = 1 << N_LOG2;
    localparam int BW = 2 * DATA_W;

    typedef enum logic [1:0] {IDLE, CFG, STREAM, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [N_LOG2-1:0]   rd_idx_q, rd_idx_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_last_q, rd_last_d;
    logic [BW-1:0]       slot0_q, slot0_d, slot1_q, slot1_d;
    logic                last0_q, last0_d, last1_q, last1_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                frame_done_q, frame_done_d;
    logic                wr_err_q, wr_err_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic [BW-1:0]       mem [N];
    logic [BW-1:0]       rd_data_q;

    logic                data_valid;
    logic                pop;
    logic                issue;
    logic [2:0]          occ;
    logic [1:0]          fill;

    // Bin RAM: writes only while idle, synchronous read for the prefetcher.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_data_q <= mem[rd_idx_q];
        end
    end

    // Reads are issued ahead of the output, including during CFG and
    // DRAIN, so the 2-entry buffer is already primed when streaming starts
    // or resumes. A read is only issued if its data will have a free slot
    // when it lands one cycle later: buffered + in-flight - leaving < 2.
    always_comb begin
        data_valid = (state_q == STREAM) && (cnt_q != 2'd0);
        pop        = data_valid && m_axis_data_tready;
        occ        = {1'b0, cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
        issue      = (state_q != IDLE) && (occ < 3'd2);
        fill       = cnt_q - {1'b0, pop};

        state_d       = state_q;
        cfg_d         = cfg_q;
        rd_idx_d      = issue ? rd_idx_q + 1'b1 : rd_idx_q;
        rd_pend_d     = issue;
        rd_last_d     = &rd_idx_q;
        slot0_d       = slot0_q;
        slot1_d       = slot1_q;
        last0_d       = last0_q;
        last1_d       = last1_q;
        cnt_d         = fill + {1'b0, rd_pend_q};
        frame_done_d  = 1'b0;
        wr_err_d      = wr_en && (state_q != IDLE);
        frame_count_d = frame_count_q;

        // Head always lives in slot0; a pop shifts slot1 down, and the
        // landing read goes into the first free slot after the pop.
        if (pop) begin
            slot0_d = slot1_q;
            last0_d = last1_q;
        end
        if (rd_pend_q) begin
            if (fill == 2'd0) begin
                slot0_d = rd_data_q;
                last0_d = rd_last_q;
            end else begin
                slot1_d = rd_data_q;
                last1_d = rd_last_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CFG;
                    cfg_d    = cfg_word;
                    rd_idx_d = '0;
                end
            end
            CFG: begin
                if (m_axis_config_tready) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pop && last0_q) begin
                    state_d       = DRAIN;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            DRAIN: begin
                // Prefetched bins of the next frame are kept when looping,
                // and discarded when returning to idle.
                if (continuous) begin
                    state_d = STREAM;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = 2'd0;
                    rd_pend_d = 1'b0;
                    rd_idx_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            rd_idx_q      <= '0;
            rd_pend_q     <= 1'b0;
            rd_last_q     <= 1'b0;
            slot0_q       <= '0;
            slot1_q       <= '0;
            last0_q       <= 1'b0;
            last1_q       <= 1'b0;
            cnt_q         <= 2'd0;
            frame_done_q  <= 1'b0;
            wr_err_q      <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            rd_idx_q      <= rd_idx_d;
            rd_pend_q     <= rd_pend_d;
            rd_last_q     <= rd_last_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            last0_q       <= last0_d;
            last1_q       <= last1_d;
            cnt_q         <= cnt_d;
            frame_done_q  <= frame_done_d;
            wr_err_q      <= wr_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign m_axis_config_tdata  = cfg_q;
    assign m_axis_config_tvalid = (state_q == CFG);
    assign m_axis_data_tdata    = slot0_q;
    assign m_axis_data_tvalid   = data_valid;
    assign m_axis_data_tlast    = data_valid && last0_q;
    assign busy                 = (state_q != IDLE);
    assign frame_done           = frame_done_q;
    assign frame_count          = frame_count_q;
    assign wr_err               = wr_err_q;

endmodule

// File: doc/fade_frame_source.md
Name: fade_frame_source

Overview:
- AXI-Stream frame transmitter that feeds the fade IFFT core.
- Holds one frequency-domain frame of N complex bins in an internal RAM, loaded through a simple write port.
- On start, issues one transform-config word on the config channel, then streams the frame on the data channel. tlast marks the final bin, and frames repeat back-to-back in continuous mode.
- Replaces hand-built stimulus in front of the IFFT in system builds.

Parameters:
- N_LOG2, 5: log2 of frame length N (default N=32).
- DATA_W, 16: width of each real/imag component.
- CFG_W, 16: config word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins a run when idle.
- continuous  in  1  sampled every frame end; 1 = start the next frame immediately.
- cfg_word  in  CFG_W  config word, latched on accepted start.
- wr_en  in  1  bin RAM write strobe.
- wr_addr  in  N_LOG2  bin index.
- wr_data  in  2*DATA_W  {imag, real}.
- wr_err  out  1  one-cycle pulse: write dropped because busy.
- m_axis_config_tdata  out  CFG_W  latched cfg_word.
- m_axis_config_tvalid  out  1
- m_axis_config_tready  in  1
- m_axis_data_tdata  out  2*DATA_W  {imag, real} of current bin.
- m_axis_data_tvalid  out  1
- m_axis_data_tready  in  1
- m_axis_data_tlast  out  1  high on bin N-1.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse on the cycle after the tlast beat is accepted.
- frame_count  out  16  frames completed since reset; wraps at 0xFFFF->0.

Behaviour:
- Reset (synchronous, dominant, any state):
  - state=IDLE; every output is 0, including frame_count.
  - Bin RAM contents are not cleared.
  - A reset mid-frame abandons the frame and issues no tlast.
- FSM states: IDLE, CFG, STREAM, DRAIN.
  - IDLE -> CFG on start. On that cycle cfg_word is latched, and m_axis_config_tvalid=1 from the next cycle.
  - CFG -> STREAM on the config handshake (tvalid&tready), after which config tvalid=0.
  - STREAM: emits bins 0..N-1 in index order.
  - DRAIN: entered when the tlast beat is accepted; lasts one cycle and pulses frame_done.
  - DRAIN -> STREAM (index 0, no config re-send) if continuous=1; otherwise DRAIN -> IDLE.
- start while busy=1 is ignored.
- Data latency: first data beat has tvalid=1 no later than 2 cycles after the config handshake.
- Throughput: with tready held high, one beat per cycle, no bubbles inside a frame. In continuous mode the DRAIN cycle is the only gap between frames.
- AXI rules:
  - tvalid is never dropped before its handshake.
  - tdata and tlast are stable while tvalid&!tready.
  - tvalid does not depend combinationally on tready.
- RAM and prefetch:
  - Synchronous-read RAM, N x 2*DATA_W.
  - A 2-entry prefetch/skid buffer sustains full rate under arbitrary tready toggling.
  - The read index wraps N-1 -> 0 at frame end.
- Writes:
  - Accepted only when busy=0; they take effect for the next run.
  - wr_en while busy=1 is dropped and pulses wr_err on the following cycle.
  - A write and start in the same idle cycle: the write is committed and is visible in that run.
- tlast is asserted only on bin N-1, exactly once per frame.
- frame_count increments on the same edge that raises frame_done.

Test Plan:
- Basic frame:
  - Stimulus: with N=32, load bin k={-k, 32*k}. Pulse start with cfg_word=0x02AC. Hold both treadys high.
  - Response: one config beat, 0x02AC. Then 32 consecutive data beats, tdata[k]={16'(-k), 16'(32k)}, tlast only on beat 31. frame_done pulses once, frame_count=1, busy returns 0.
- Backpressure:
  - Stimulus: as the basic frame, but data tready follows an LFSR pattern, high about 50%.
  - Response: same 32-beat sequence, no loss or duplication; tdata held stable across every stall.
- Config stall:
  - Stimulus: config tready held low for 20 cycles.
  - Response: config tvalid held high with 0x02AC, data tvalid stays 0, stream begins after the handshake.
- Continuous:
  - Stimulus: continuous=1 for 3 frames, then deassert mid-frame 3.
  - Response: exactly 1 config beat; frames 2 and 3 each follow a 1-cycle gap; 3 tlast beats; frame_count=3; IDLE after frame 3.
- Write while busy:
  - Stimulus: wr_en to addr 5 during STREAM.
  - Response: wr_err pulses; the bin 5 value in the next run is unchanged. The same write issued while idle does take effect.
- Reset mid-frame:
  - Stimulus: assert reset at beat 10 for 1 cycle, then start again.
  - Response: all outputs 0 on the next cycle. The new run re-sends config and restarts from bin 0 with the original RAM data intact.
